// File: rtl/or_bank_pkg.sv
// Shared types and constants for the or_bank block.
// OR_BANK_STICKY_EN selects the accumulating (sticky) build; see or_bank.sv.
package or_bank_pkg;

    localparam int FIFO_DEPTH = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/or_bank_fifo.sv
// Two-entry output buffer; o_ready depends only on the registered occupancy.
// Valid/ready: a push happens when i_push is high (caller guarantees o_ready), a pop when o_valid & i_pop.
module or_bank_fifo
    import or_bank_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_ready
);

    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTRW-1:0]  r_wr_ptr;
    logic [PTRW-1:0]  r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign o_valid = (r_count != '0);
    assign o_ready = (r_count < CW'(FIFO_DEPTH));
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop & o_valid;

    // Clear wipes the storage too, so a flushed buffer presents zero just like after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTRW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTRW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/or_bank.sv
// Bank of WIDTH 2-input OR gates behind a valid/ready input and a 2-entry output buffer.
// Define OR_BANK_STICKY_EN to enable multi-beat accumulation (acc input); otherwise acc is ignored.
module or_bank
    import or_bank_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert,
    input  logic             acc,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [CNTW-1:0]  beat_cnt,
    output state_t           o_dbg_state
);

    logic             w_accept;
    logic             w_push;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_push_data;
    logic [CNTW-1:0]  r_beat_cnt;

    assign w_accept = in_valid & in_ready & ~clear;
    assign w_result = a | b;
    assign beat_cnt = r_beat_cnt;

`ifdef OR_BANK_STICKY_EN
    state_t           r_state;
    logic [WIDTH-1:0] r_acc_reg;
    logic [WIDTH-1:0] w_merged;

    assign w_merged    = (r_state == ACCUM) ? (r_acc_reg | w_result) : w_result;
    assign w_push      = w_accept & ~acc;
    assign w_push_data = w_merged ^ {WIDTH{invert}};
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc_reg <= '0;
        end else if (clear) begin
            r_state   <= IDLE;
            r_acc_reg <= '0;
        end else if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (acc) begin
                        r_state   <= ACCUM;
                        r_acc_reg <= w_merged;
                    end
                end
                ACCUM: begin
                    if (acc) begin
                        r_acc_reg <= w_merged;
                    end else begin
                        r_state   <= IDLE;
                        r_acc_reg <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`else
    logic w_unused_acc;

    assign w_unused_acc = acc;
    assign w_push       = w_accept;
    assign w_push_data  = w_result ^ {WIDTH{invert}};
    assign o_dbg_state  = IDLE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (clear) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CNTW'(1);
        end
    end

    or_bank_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (out_ready),
        .o_data  (out),
        .o_valid (out_valid),
        .o_ready (in_ready)
    );

endmodule

// File: doc/or_bank.md
OR_BANK -- requirements
Module: or_bank

Interface
REQ-001 Parameter WIDTH, default 4, is the number of independent 2-input OR gates (bits per beat).
REQ-002 Parameter CNTW, default 8, is the width of the accepted-beat counter.
REQ-003 Port clk, input, 1, is the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, is the reset; it is asynchronous and active-high.
REQ-005 Port in_valid, input, 1, is the input beat valid.
REQ-006 Port in_ready, output, 1, is high when a beat can be accepted.
REQ-007 Port a, input, WIDTH, is operand A.
REQ-008 Port b, input, WIDTH, is operand B.
REQ-009 Port invert, input, 1, selects NOR output and is sampled with the beat that pushes.
REQ-010 Port acc, input, 1, marks a non-final beat to be accumulated.
REQ-011 Port clear, input, 1, is a synchronous flush.
REQ-012 Port out_valid, output, 1, is the output beat valid.
REQ-013 Port out_ready, input, 1, is the output beat consumed.
REQ-014 Port out, output, WIDTH, is the result.
REQ-015 Port beat_cnt, output, CNTW, counts accepted beats.

Function
REQ-016 A beat shall be accepted on an edge where in_valid and in_ready are both high and clear is low.
REQ-017 Per-beat result = a | b, bitwise.
REQ-018 The output buffer shall be a 2-entry FIFO; in_ready = (occupancy < 2), derived from registers only, with no combinational path from out_ready.
REQ-019 Latency: a pushing beat accepted at edge N into an empty buffer shall give out_valid=1 and out valid after edge N.
REQ-020 Pop occurs on an edge with out_valid and out_ready high; out shall hold stable while out_valid=1 and out_ready=0.
REQ-021 A simultaneous push and pop at occupancy 1 shall leave occupancy 1 and deliver entries in order.
REQ-022 A pop at occupancy 0 shall be impossible (out_valid=0), and a push at occupancy 2 shall be impossible (in_ready=0).
REQ-023 The accumulator FSM shall have states IDLE (no partial) and ACCUM (partial held in acc_reg).
REQ-024 IDLE with an accepted beat and acc=1 shall go to ACCUM with acc_reg = result and no push.
REQ-025 ACCUM with an accepted beat and acc=1 shall remain in ACCUM with acc_reg |= result and no push.
REQ-026 An accepted beat with acc=0 shall push v = (state==ACCUM ? acc_reg|result : result), inverted bitwise if invert=1, and return the FSM to IDLE.
REQ-027 Accumulating beats shall be accepted even when occupancy = 2? No: in_ready rules are uniform and no beat is accepted at occupancy 2.
REQ-028 beat_cnt shall increment by 1 per accepted beat and wrap modulo 2^CNTW.
REQ-029 When clear=1 at an edge, the FSM shall go to IDLE, acc_reg shall be zeroed, the FIFO emptied, and beat_cnt zeroed; clear overrides a same-edge accept and pop.

Reset
REQ-030 rst=1 shall asynchronously force FSM=IDLE, acc_reg=0, FIFO empty, out_valid=0, out=0, beat_cnt=0, and in_ready=1 (after reset releases).
REQ-031 Reset asserted mid-accumulation shall discard the partial result with no push.

Configuration
REQ-032 Macro OR_BANK_STICKY_EN, when defined, shall include the accumulator FSM, acc_reg and the acc behaviour as above.
REQ-033 Without OR_BANK_STICKY_EN, acc shall be ignored, every accepted beat shall push (~)(a|b), and no accumulator registers shall exist.

Structure
REQ-034 Package or_bank_pkg shall hold the FSM state enum (IDLE, ACCUM) and the FIFO depth constant (2).
REQ-035 The 2-entry FIFO shall be a sub-module, or_bank_fifo, parametrised by WIDTH.

Verification
REQ-036 Reset, then push a=4'b0001, b=4'b0100, invert=0, acc=0 -> out=4'b0101 and out_valid=1 after the next edge; beat_cnt=1.
REQ-037 Beats (a,b) = (1,0) acc=1, (2,0) acc=1, (8,0) acc=0 invert=1 -> a single output 4'b0100, with beat_cnt=3.
REQ-038 Hold out_ready=0 and offer 3 beats -> 2 are accepted, in_ready=0, and out holds the first value; raise out_ready -> both values drain in order.
REQ-039 Assert clear with occupancy 2 and an ACCUM partial plus in_valid high -> FIFO empty, IDLE, beat_cnt=0, and the beat is not accepted.
REQ-040 Assert rst during ACCUM, then send (3,0) acc=0 -> out=4'b0011, with no stale partial.
REQ-041 Push 256 beats with CNTW=8 -> beat_cnt wraps to 0.
